// File: rtl/instr_entry_ctrl.sv
// Writer side of the instruction queue: turns debounced button levels into one-cycle
// fifo strobes, mirrors fifo occupancy and flags rejected requests for a fixed hold time.
module instr_entry_ctrl #(
    parameter int  DEPTH      = 8,
    parameter int  REJ_CYCLES = 25_000_000,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          save_lvl,
    input  logic          delete_lvl,
    input  logic          clear_lvl,
    input  logic [3:0]    sw,
    input  logic          exec_active,
    input  logic          rd_pulse,
    output logic          wr_en,
    output logic [3:0]    wr_data,
    output logic          del_en,
    output logic          clr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic [3:0]    last_instr,
    output logic          reject
);

    localparam int RW = (REJ_CYCLES > 1) ? $clog2(REJ_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        DELETE = 3'd2,
        CLEAR  = 3'd3,
        REJECT = 3'd4,
        LOCKED = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            save_prev_q, delete_prev_q, clear_prev_q;
    logic [CW-1:0]   count_q, count_d;
    logic [RW-1:0]   rej_cnt_q, rej_cnt_d;
    logic [3:0]      last_instr_q, last_instr_d;
    logic            ev_save, ev_delete, ev_clear;
    logic            save_ok, rd_ok;

    assign ev_save   = save_lvl   & ~save_prev_q;
    assign ev_delete = delete_lvl & ~delete_prev_q;
    assign ev_clear  = clear_lvl  & ~clear_prev_q;
    assign save_ok   = (count_q < CW'(DEPTH)) && (sw[3:2] != 2'b00);
    assign rd_ok     = rd_pulse && (count_q != '0);

    // History resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            save_prev_q   <= 1'b1;
            delete_prev_q <= 1'b1;
            clear_prev_q  <= 1'b1;
            count_q       <= '0;
            rej_cnt_q     <= '0;
            last_instr_q  <= '0;
        end else begin
            state_q       <= state_d;
            save_prev_q   <= save_lvl;
            delete_prev_q <= delete_lvl;
            clear_prev_q  <= clear_lvl;
            count_q       <= count_d;
            rej_cnt_q     <= rej_cnt_d;
            last_instr_q  <= last_instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ev_clear)         state_d = CLEAR;
                else if (exec_active) state_d = LOCKED;
                else if (ev_delete)   state_d = (count_q != '0) ? DELETE : REJECT;
                else if (ev_save)     state_d = save_ok ? WRITE : REJECT;
            end
            WRITE, DELETE, CLEAR: state_d = IDLE;
            REJECT: begin
                if (ev_clear)               state_d = CLEAR;
                else if (rej_cnt_q == '0)   state_d = IDLE;
            end
            LOCKED: begin
                if (ev_clear)          state_d = CLEAR;
                else if (!exec_active) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Count moves on the edge that enters WRITE/DELETE so the next request sees it.
    always_comb begin
        count_d = count_q;
        if (state_d == CLEAR)
            count_d = '0;
        else if (state_d == WRITE)
            count_d = rd_ok ? count_q : count_q + CW'(1);
        else if (state_d == DELETE)
            count_d = rd_ok ? ((count_q >= CW'(2)) ? count_q - CW'(2) : '0) : count_q - CW'(1);
        else if (rd_ok)
            count_d = count_q - CW'(1);
    end

    always_comb begin
        rej_cnt_d = rej_cnt_q;
        if (state_d == REJECT && state_q != REJECT)
            rej_cnt_d = RW'(REJ_CYCLES - 1);
        else if (state_q == REJECT && rej_cnt_q != '0)
            rej_cnt_d = rej_cnt_q - RW'(1);
    end

    always_comb begin
        last_instr_d = last_instr_q;
        if (state_d == WRITE)
            last_instr_d = sw;
    end

    // wr_data and last_instr share one register: both hold the last accepted sw value.
    always_comb begin
        wr_en      = (state_q == WRITE);
        del_en     = (state_q == DELETE);
        clr        = (state_q == CLEAR);
        reject     = (state_q == REJECT);
        wr_data    = last_instr_q;
        last_instr = last_instr_q;
        count      = count_q;
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
    end

endmodule

// File: tb/tb_instr_entry_ctrl.sv
// Directed bench for instr_entry_ctrl with DEPTH=4, REJ_CYCLES=3.
module tb_instr_entry_ctrl;
    localparam int DEPTH = 4;
    localparam int REJ   = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          save_lvl, delete_lvl, clear_lvl;
    logic [3:0]    sw;
    logic          exec_active, rd_pulse;
    logic          wr_en, del_en, clr, full, empty, reject;
    logic [3:0]    wr_data, last_instr;
    logic [CW-1:0] count;

    int n_chk  = 0;
    int n_fail = 0;
    int pushes;

    instr_entry_ctrl #(.DEPTH(DEPTH), .REJ_CYCLES(REJ)) dut (
        .clk(clk), .rst_n(rst_n),
        .save_lvl(save_lvl), .delete_lvl(delete_lvl), .clear_lvl(clear_lvl),
        .sw(sw), .exec_active(exec_active), .rd_pulse(rd_pulse),
        .wr_en(wr_en), .wr_data(wr_data), .del_en(del_en), .clr(clr),
        .count(count), .full(full), .empty(empty),
        .last_instr(last_instr), .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic save_ok_pulse(input logic [3:0] v, input int exp_cnt);
        sw = v; save_lvl = 1'b1; step();
        chk("save_wr_en", wr_en, 1);
        chk("save_wr_data", wr_data, v);
        chk("save_count", count, exp_cnt);
        save_lvl = 1'b0; step();
        chk("save_wr_en_off", wr_en, 0);
    endtask

    task automatic do_clear();
        clear_lvl = 1'b1; step();
        chk("clear_clr", clr, 1);
        chk("clear_count", count, 0);
        clear_lvl = 1'b0; step();
        chk("clear_clr_off", clr, 0);
    endtask

    task automatic reject_window(input string tag);
        for (int i = 1; i < REJ; i++) begin
            step();
            chk({tag, "_reject_hold"}, reject, 1);
        end
        step();
        chk({tag, "_reject_end"}, reject, 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_del_en", del_en, 0);
        chk("rst_clr", clr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_last", last_instr, 0);
        chk("rst_reject", reject, 0);
    endtask

    initial begin
        rst_n = 1'b0; save_lvl = 0; delete_lvl = 0; clear_lvl = 0;
        sw = 4'b0110; exec_active = 0; rd_pulse = 0;
        #2;
        check_reset_vals();
        step(); step();
        rst_n = 1'b1; step();

        // 1: single accepted save
        save_lvl = 1'b1; step();
        chk("t1_wr_en", wr_en, 1);
        chk("t1_wr_data", wr_data, 6);
        chk("t1_last", last_instr, 6);
        chk("t1_count", count, 1);
        chk("t1_empty", empty, 0);
        save_lvl = 1'b0; step();
        chk("t1_wr_en_off", wr_en, 0);
        chk("t1_count_hold", count, 1);

        // 2: fill to DEPTH, then overflow reject
        do_clear();
        for (int i = 1; i <= DEPTH; i++) save_ok_pulse(4'b0101, i);
        chk("t2_full", full, 1);
        save_lvl = 1'b1; step();
        chk("t2_ovf_wr_en", wr_en, 0);
        chk("t2_ovf_reject", reject, 1);
        chk("t2_ovf_count", count, 4);
        save_lvl = 1'b0;
        reject_window("t2");

        // 3: underflow delete and zero-torque save
        do_clear();
        delete_lvl = 1'b1; step();
        chk("t3_del_en", del_en, 0);
        chk("t3_del_reject", reject, 1);
        delete_lvl = 1'b0;
        reject_window("t3del");
        sw = 4'b0001; save_lvl = 1'b1; step();
        chk("t3_zt_wr_en", wr_en, 0);
        chk("t3_zt_reject", reject, 1);
        chk("t3_zt_count", count, 0);
        save_lvl = 1'b0;
        reject_window("t3zt");

        // 4: lockout while executor runs
        save_ok_pulse(4'b0101, 1);
        save_ok_pulse(4'b0110, 2);
        exec_active = 1'b1; step();
        save_lvl = 1'b1; step();
        chk("t4_save_wr_en", wr_en, 0);
        chk("t4_save_reject", reject, 0);
        save_lvl = 1'b0; step();
        delete_lvl = 1'b1; step();
        chk("t4_del_en", del_en, 0);
        chk("t4_del_reject", reject, 0);
        delete_lvl = 1'b0; step();
        rd_pulse = 1'b1; step();
        chk("t4_rd1_count", count, 1);
        step();
        chk("t4_rd2_count", count, 0);
        step();
        chk("t4_rd_at_zero", count, 0);
        rd_pulse = 1'b0;
        clear_lvl = 1'b1; step();
        chk("t4_clr", clr, 1);
        clear_lvl = 1'b0; exec_active = 1'b0; step();
        chk("t4_clr_off", clr, 0);

        // 5: save with same-edge read, held save, priorities, delete with read
        save_ok_pulse(4'b0101, 1);
        save_ok_pulse(4'b0101, 2);
        save_ok_pulse(4'b0101, 3);
        sw = 4'b1010; save_lvl = 1'b1; rd_pulse = 1'b1; step();
        chk("t5_rd_wr_en", wr_en, 1);
        chk("t5_rd_wr_count", count, 3);
        rd_pulse = 1'b0;
        pushes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (wr_en) pushes++;
        end
        chk("t5_held_pushes", pushes, 0);
        chk("t5_held_count", count, 3);
        save_lvl = 1'b0; step();
        delete_lvl = 1'b1; save_lvl = 1'b1; step();
        chk("t5_prio_del_en", del_en, 1);
        chk("t5_prio_wr_en", wr_en, 0);
        chk("t5_prio_count", count, 2);
        delete_lvl = 1'b0; save_lvl = 1'b0; step();
        delete_lvl = 1'b1; rd_pulse = 1'b1; step();
        chk("t5_delrd_count", count, 0);
        delete_lvl = 1'b0; rd_pulse = 1'b0; step();
        save_ok_pulse(4'b1001, 1);
        delete_lvl = 1'b1; rd_pulse = 1'b1; step();
        chk("t5_floor_del_en", del_en, 1);
        chk("t5_floor_count", count, 0);
        chk("t5_del_last", last_instr, 9);
        delete_lvl = 1'b0; rd_pulse = 1'b0; step();
        save_ok_pulse(4'b0110, 1);
        clear_lvl = 1'b1; save_lvl = 1'b1; step();
        chk("t5_cs_clr", clr, 1);
        chk("t5_cs_wr_en", wr_en, 0);
        chk("t5_cs_count", count, 0);
        clear_lvl = 1'b0; save_lvl = 1'b0; step();

        // 6: reset in the middle of a held save
        sw = 4'b0111; save_lvl = 1'b1; step();
        chk("t6_pre_wr_en", wr_en, 1);
        step();
        rst_n = 1'b0; #1;
        check_reset_vals();
        step();
        rst_n = 1'b1;
        pushes = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wr_en) pushes++;
        end
        chk("t6_no_push_held", pushes, 0);
        save_lvl = 1'b0; step();
        save_lvl = 1'b1; step();
        chk("t6_repress_wr_en", wr_en, 1);
        chk("t6_repress_count", count, 1);
        save_lvl = 1'b0; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
